// File: rtl/seg7_pkg.sv
// Shared types and the hex font for the multiplexed 7-segment 74HC595 driver.
package seg7_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int CLEAR_TICKS = 2;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  // Segment order: bit0 = a ... bit6 = g
  function automatic logic [6:0] seg7_font(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_frame_builder.sv
// Combinational builder of one 16-bit 595 frame: {segment byte, digit select byte}.
module seg7_frame_builder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic [2:0]              i_digit,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  output logic [FRAME_BITS-1:0]   o_frame
);

  logic [3:0] w_nib;
  logic       w_dp;
  logic       w_blank;
  logic [7:0] w_seg_raw;
  logic [7:0] w_seg;
  logic [7:0] w_sel;

  always_comb begin
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(i_digit) == i) begin
        w_nib   = i_value[4*i +: 4];
        w_dp    = i_dp[i];
        w_blank = i_blank[i];
      end
    end
  end

  assign w_seg_raw = w_blank ? 8'h00 : {w_dp, seg7_font(w_nib)};
  assign w_seg     = (SEG_ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw;

  // Select lines for absent digits stay at the inactive level
  for (genvar gi = 0; gi < 8; gi++) begin : g_sel
    assign w_sel[gi] = ((gi < NUM_DIGITS) && (int'(i_digit) == gi)) ^ (DIG_ACTIVE_LOW != 0);
  end

  assign o_frame = {w_seg, w_sel};

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit 7-segment scan driver for two chained 74HC595.
// Optional SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits when a new value is applied.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 6250,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [4*NUM_DIGITS-1:0] i_load_value,
  input  logic [NUM_DIGITS-1:0]   i_load_dp,
  input  logic [NUM_DIGITS-1:0]   i_load_blank,
  output logic                    o_sclk,
  output logic                    o_serial_data,
  output logic                    o_rclk,
  output logic                    o_srclr
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]        r_div;
  state_t                  r_state, w_state_next;
  logic [3:0]              r_cnt, w_cnt_next;
  logic [2:0]              r_digit, w_digit_next;
  logic [FRAME_BITS-1:0]   r_shreg, w_shreg_next;
  logic                    r_sclk, w_sclk_next;
  logic                    r_rclk, w_rclk_next;
  logic                    r_srclr, w_srclr_next;
  logic                    r_ready;
  logic [4*NUM_DIGITS-1:0] r_pend_value, r_act_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank, r_act_blank;

  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_accept;
  logic [2:0]              w_digit_adv;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic [NUM_DIGITS-1:0]   w_apply_blank;
  logic [4*NUM_DIGITS-1:0] w_fb_value;
  logic [NUM_DIGITS-1:0]   w_fb_dp;
  logic [NUM_DIGITS-1:0]   w_fb_blank;
  logic [FRAME_BITS-1:0]   w_frame;

  assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_wrap      = w_tick && (r_state == ST_LATCH) && (r_cnt == 4'd1) &&
                       (r_digit == 3'(NUM_DIGITS - 1));
  assign w_digit_adv = ((r_state != ST_LATCH) || (r_digit == 3'(NUM_DIGITS - 1))) ? 3'd0
                                                                                  : r_digit + 3'd1;

  assign o_load_ready = r_ready && !w_wrap;
  assign w_accept     = i_load_valid && o_load_ready;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic w_lz_run;
  always_comb begin
    w_lz_blank = '0;
    w_lz_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_lz_run      = w_lz_run && (r_pend_value[4*i +: 4] == 4'h0);
      w_lz_blank[i] = w_lz_run;
    end
  end
`else
  assign w_lz_blank = '0;
`endif

  assign w_apply_blank = r_pend_blank | w_lz_blank;

  // The first frame of a new scan must already see the values being applied
  assign w_fb_value = w_wrap ? r_pend_value  : r_act_value;
  assign w_fb_dp    = w_wrap ? r_pend_dp     : r_act_dp;
  assign w_fb_blank = w_wrap ? w_apply_blank : r_act_blank;

  seg7_frame_builder #(
    .NUM_DIGITS    (NUM_DIGITS),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW),
    .DIG_ACTIVE_LOW(DIG_ACTIVE_LOW)
  ) u_frame_builder (
    .i_digit(w_digit_adv),
    .i_value(w_fb_value),
    .i_dp   (w_fb_dp),
    .i_blank(w_fb_blank),
    .o_frame(w_frame)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_digit_next = r_digit;
    w_shreg_next = r_shreg;
    w_sclk_next  = r_sclk;
    w_rclk_next  = r_rclk;
    if (w_tick) begin
      unique case (r_state)
        ST_CLEAR: begin
          if (r_cnt == 4'(CLEAR_TICKS - 1)) begin
            w_state_next = ST_SHIFT;
            w_cnt_next   = 4'd0;
            w_digit_next = w_digit_adv;
            w_shreg_next = w_frame;
            w_sclk_next  = 1'b0;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        ST_SHIFT: begin
          // r_cnt counts bits whose rising edge has already been issued
          if (!r_sclk) begin
            w_sclk_next = 1'b1;
          end else if (r_cnt == 4'(FRAME_BITS - 1)) begin
            w_sclk_next  = 1'b0;
            w_rclk_next  = 1'b1;
            w_cnt_next   = 4'd0;
            w_state_next = ST_LATCH;
          end else begin
            w_sclk_next  = 1'b0;
            w_shreg_next = {r_shreg[FRAME_BITS-2:0], 1'b0};
            w_cnt_next   = r_cnt + 4'd1;
          end
        end
        ST_LATCH: begin
          if (r_cnt == 4'd0) begin
            w_rclk_next = 1'b0;
            w_cnt_next  = 4'd1;
          end else begin
            w_state_next = ST_SHIFT;
            w_cnt_next   = 4'd0;
            w_digit_next = w_digit_adv;
            w_shreg_next = w_frame;
          end
        end
        default: w_state_next = ST_CLEAR;
      endcase
    end
  end

  assign w_srclr_next = (w_state_next != ST_CLEAR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_state <= ST_CLEAR;
      r_cnt   <= 4'd0;
      r_digit <= 3'd0;
      r_shreg <= '0;
      r_sclk  <= 1'b0;
      r_rclk  <= 1'b0;
      r_srclr <= 1'b0;
    end else begin
      r_div   <= w_tick ? '0 : r_div + DIV_W'(1);
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_digit <= w_digit_next;
      r_shreg <= w_shreg_next;
      r_sclk  <= w_sclk_next;
      r_rclk  <= w_rclk_next;
      r_srclr <= w_srclr_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready      <= 1'b1;
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
    end else if (w_wrap) begin
      r_act_value <= r_pend_value;
      r_act_dp    <= r_pend_dp;
      r_act_blank <= w_apply_blank;
      r_ready     <= 1'b1;
    end else if (w_accept) begin
      r_pend_value <= i_load_value;
      r_pend_dp    <= i_load_dp;
      r_pend_blank <= i_load_blank;
      r_ready      <= 1'b0;
    end
  end

  assign o_sclk        = r_sclk;
  assign o_rclk        = r_rclk;
  assign o_srclr       = r_srclr;
  assign o_serial_data = r_shreg[FRAME_BITS-1];

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a behavioural 595 pair capturing latched frames.
module tb_seg7_scan_driver;

  localparam int ND = 8;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_value = '0;
  logic [7:0]  load_dp = '0;
  logic [7:0]  load_blank = '0;
  logic        sclk, serial_data, rclk, srclr;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] sr595 = '0;
  logic [15:0] q_frames[$];
  logic [6:0]  font_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .CLK_DIV(2), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_valid(load_valid), .o_load_ready(load_ready),
    .i_load_value(load_value), .i_load_dp(load_dp), .i_load_blank(load_blank),
    .o_sclk(sclk), .o_serial_data(serial_data), .o_rclk(rclk), .o_srclr(srclr)
  );

  always @(posedge sclk or negedge srclr) begin
    if (!srclr) sr595 <= '0;
    else        sr595 <= {sr595[14:0], serial_data};
  end

  always @(posedge rclk) q_frames.push_back(sr595);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [15:0] exp_frame(input logic [31:0] v, input logic [7:0] dp,
                                            input logic [7:0] bl, input int d);
    logic       blank;
    logic       zrun;
    logic [7:0] seg, sel, one;
    blank = bl[d];
    if (LZB && d > 0) begin
      zrun = 1'b1;
      for (int j = 7; j >= d; j--) zrun = zrun & (v[4*j +: 4] == 4'h0);
      blank = blank | zrun;
    end
    seg = blank ? 8'h00 : {dp[d], font_tbl[v[4*d +: 4]]};
    one = 8'h01;
    sel = ~(one << d);
    return {seg, sel};
  endfunction

  task automatic wait_frame(output logic [15:0] f);
    int n = 0;
    while (q_frames.size() == 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q_frames.size() == 0) begin
      check("frame_timeout", q_frames.size(), 1);
      f = '0;
    end else begin
      f = q_frames.pop_front();
    end
  endtask

  task automatic check_scan(input string tag, input logic [31:0] v, input logic [7:0] dp,
                            input logic [7:0] bl);
    logic [15:0] f;
    for (int d = 0; d < ND; d++) begin
      wait_frame(f);
      check($sformatf("%s_d%0d", tag, d), {16'h0, f}, {16'h0, exp_frame(v, dp, bl, d)});
    end
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] bl);
    @(negedge clk);
    load_valid = 1'b1;
    load_value = v;
    load_dp    = dp;
    load_blank = bl;
    for (int n = 0; n < 2000; n++) begin
      if (load_ready) break;
      @(negedge clk);
    end
    if (!load_ready) check("load_timeout", load_ready, 1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check("ready_drop", load_ready, 0);
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (load_ready) break;
    end
    check("ready_rise", load_ready, 1);
  endtask

  task automatic release_and_measure_clear();
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      n = k;
      if (srclr) break;
    end
    check("clear_len", n, 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"},  sclk, 0);
    check({tag, "_rclk"},  rclk, 0);
    check({tag, "_srclr"}, srclr, 0);
    check({tag, "_sdata"}, serial_data, 0);
    check({tag, "_ready"}, load_ready, 1);
  endtask

  initial begin
    // 1: reset and power-up scan of zeros
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    release_and_measure_clear();
    check("no_latch_in_clear", q_frames.size(), 0);
    check_scan("init", 32'h0, 8'h00, 8'h00);

    // 2: plain value
    do_load(32'h1234_5678, 8'h00, 8'h00);
    wait_ready();
    q_frames.delete();
    check_scan("val", 32'h1234_5678, 8'h00, 8'h00);

    // 3: back-to-back loads; second waits for the wrap
    repeat (20) @(negedge clk);
    do_load(32'h89AB_CDEF, 8'h00, 8'h00);
    repeat (20) @(negedge clk);
    check("holdoff_ready", load_ready, 0);
    do_load(32'h0F1E_2D3C, 8'h00, 8'h00);
    q_frames.delete();
    check_scan("bbA", 32'h89AB_CDEF, 8'h00, 8'h00);
    wait_ready();
    q_frames.delete();
    check_scan("bbB", 32'h0F1E_2D3C, 8'h00, 8'h00);

    // 4: decimal point and explicit blank
    do_load(32'h1234_5678, 8'h01, 8'h80);
    wait_ready();
    q_frames.delete();
    check_scan("dpbl", 32'h1234_5678, 8'h01, 8'h80);

    // 5: leading zeros (blanked only when the option is built in)
    do_load(32'h0000_00A0, 8'h00, 8'h00);
    wait_ready();
    q_frames.delete();
    check_scan("lz", 32'h0000_00A0, 8'h00, 8'h00);

    // 6: reset mid-frame with a load pending
    do_load(32'h5555_5555, 8'hFF, 8'h00);
    @(posedge sclk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    q_frames.delete();
    repeat (3) @(posedge clk);
    release_and_measure_clear();
    check_scan("post", 32'h0, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
